i2s_rx: RTL and testbench

Philips I2S slave receiver. It takes BCLK, LRCK and SDATA from an external I2S master, such as an ADC or a codec, and oversamples them on the 12 MHz system clock. It deserialises one left and one right word per frame and hands the stereo pair to the grain-buffer writer over a valid/ready interface. It is the capture-side counterpart of the synth's I2S output path and shares the same pin bank conventions.

---
 rtl/i2s_rx.sv | 126 ++++++++++++
 tb/tb_i2s_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S slave receiver. Oversamples BCLK/LRCK/SDATA on clk and
// delivers one left/right pair per frame over valid/ready.
module i2s_rx #(
  parameter int SAMPLE_BITS   = 16,
  parameter int MAX_SLOT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrck,
  input  logic                   i2s_data,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   locked,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   err_clr
);
  localparam logic [5:0] SB = 6'(SAMPLE_BITS);
  localparam logic [5:0] MX = 6'(MAX_SLOT_BITS);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             bclk_sync_q, bclk_sync_d, lrck_sync_q, lrck_sync_d, data_sync_q, data_sync_d;
  logic                   bclk_prev_q, bclk_prev_d, lrck_dly_q, lrck_dly_d;
  logic [5:0]             cnt_q, cnt_d, cnt_inc;
  logic [SAMPLE_BITS-1:0] sr_l_q, sr_l_d, sr_r_q, sr_r_d, hold_q, hold_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d, ch_sr, word_new, word_fin;
  logic                   valid_q, valid_d, locked_q, locked_d, err_q, err_d, ovr_q, ovr_d;
  logic                   rise, boundary, shift_en, complete, overflow, done, busy;

  always_comb begin
    bclk_sync_d = {bclk_sync_q[0], i2s_bclk};
    lrck_sync_d = {lrck_sync_q[0], i2s_lrck};
    data_sync_d = {data_sync_q[0], i2s_data};
    bclk_prev_d = bclk_sync_q[1];
    rise        = bclk_sync_q[1] && !bclk_prev_q;
    lrck_dly_d  = rise ? lrck_sync_q[1] : lrck_dly_q;
    // The bit on a boundary rise still belongs to the channel held in lrck_dly_q.
    boundary    = rise && (lrck_sync_q[1] != lrck_dly_q);
    cnt_inc     = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;
    cnt_d       = !rise ? cnt_q : boundary ? 6'd0 : cnt_inc;
    shift_en    = cnt_q < SB;
    ch_sr       = lrck_dly_q ? sr_r_q : sr_l_q;
    word_new    = {ch_sr[SAMPLE_BITS-2:0], data_sync_q[1]};
    word_fin    = shift_en ? word_new : ch_sr;
    sr_l_d      = (rise && !lrck_dly_q && shift_en) ? word_new : sr_l_q;
    sr_r_d      = (rise && lrck_dly_q && shift_en) ? word_new : sr_r_q;
    complete    = cnt_inc >= SB;
    overflow    = cnt_inc > MX;
    state_d     = state_q;
    err_d       = 1'b0;
    hold_d      = hold_q;
    done        = 1'b0;
    if (rise && state_q != UNLOCKED && overflow) begin
      err_d   = 1'b1;
      state_d = UNLOCKED;
    end else if (boundary) begin
      if (state_q == UNLOCKED) state_d = lrck_sync_q[1] ? UNLOCKED : LEFT;
      else if (!complete) begin
        err_d   = 1'b1;
        state_d = UNLOCKED;
      end else if (state_q == LEFT) begin
        hold_d  = word_fin;
        state_d = RIGHT;
      end else begin
        done    = 1'b1;
        state_d = LEFT;
      end
    end
    busy     = valid_q && !sample_ready;
    valid_d  = done || busy;
    left_d   = (done && !busy) ? hold_q : left_q;
    right_d  = (done && !busy) ? word_fin : right_q;
    ovr_d    = (done && busy) || (ovr_q && !err_clr);
    locked_d = state_d != UNLOCKED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_dly_q  <= 1'b0;
      cnt_q       <= '0;
      sr_l_q      <= '0;
      sr_r_q      <= '0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      data_sync_q <= data_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_dly_q  <= lrck_dly_d;
      cnt_q       <= cnt_d;
      sr_l_q      <= sr_l_d;
      sr_r_q      <= sr_r_d;
      hold_q      <= hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign frame_err    = err_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: table-driven frames, directed corner cases and a randomized
// stream checked against a slot-level model of the I2S framing rules.
module tb_i2s_rx;
  logic clk = 0, rst_n = 0, i2s_bclk = 0, i2s_lrck = 0, i2s_data = 0, sample_ready = 1, err_clr = 0;
  logic [15:0] left_sample, right_sample;
  logic sample_valid, locked, frame_err, overrun;

  i2s_rx #(.SAMPLE_BITS(16), .MAX_SLOT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
    .left_sample(left_sample), .right_sample(right_sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .locked(locked), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] l, r;
    int          slot;
    logic [15:0] el, er;
  } vec_t;

  vec_t tv[5];
  int checks = 0, failures = 0, xfers = 0, vcyc = 0, errs = 0;
  logic rec = 0;
  logic [15:0] last_l = 0, last_r = 0;
  logic [31:0] got_q[$], exp_q[$];
  logic rl_q[$], rd_q[$];
  int pool[13] = '{8, 12, 15, 16, 16, 16, 17, 20, 24, 32, 32, 33, 36};

  always @(negedge clk) begin
    if (sample_valid) vcyc++;
    if (sample_valid && sample_ready) begin
      xfers++;
      last_l = left_sample;
      last_r = right_sample;
      if (rec) got_q.push_back({left_sample, right_sample});
    end
    if (frame_err) errs++;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic rise(input logic l, input logic d);
    i2s_bclk = 0;
    i2s_lrck = l;
    i2s_data = d;
    #40;
    i2s_bclk = 1;
    if (rec) begin
      rl_q.push_back(l);
      rd_q.push_back(d);
    end
    #40;
  endtask

  // One channel slot: MSB first, LRCK flips on the slot's last bit (one-bit delay).
  task automatic send_slot(input logic c, input logic [31:0] w, input int len);
    for (int k = 0; k < len; k++)
      rise((k == len - 1) ? ~c : c, (k < 32) ? w[31-k] : 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset;
    i2s_bclk = 0;
    i2s_lrck = 0;
    i2s_data = 0;
    err_clr  = 0;
    rst_n    = 0;
    #30;
    rst_n = 1;
    #20;
  endtask

  task automatic run_model(output int merr, output logic mlk);
    int mode, b, len;
    logic prev;
    logic [15:0] w, lw;
    mode = 0; b = -1; merr = 0; lw = 0; prev = 0;
    for (int i = 0; i < rl_q.size(); i++) begin
      if (rl_q[i] != prev) begin
        len = i - b;
        w = '0;
        for (int k = 0; k < 16 && k < len; k++) w = {w[14:0], rd_q[b+1+k]};
        if (mode != 0 && len > 32) begin
          merr++;
          mode = (len > 33 && !rl_q[i]) ? 1 : 0;
        end else if (mode == 1) begin
          if (len >= 16) begin lw = w; mode = 2; end
          else begin merr++; mode = 0; end
        end else if (mode == 2) begin
          if (len >= 16) begin exp_q.push_back({lw, w}); mode = 1; end
          else begin merr++; mode = 0; end
        end else if (!rl_q[i]) mode = 1;
        b = i;
      end
      prev = rl_q[i];
    end
    len = rl_q.size() - 1 - b;
    if (mode != 0 && len > 32) begin merr++; mode = 0; end
    mlk = (mode != 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, v0, e0, merr;
    logic mlk, c;
    tv[0] = '{32'h1234_0000, 32'hABCD_0000, 16, 16'h1234, 16'hABCD};
    tv[1] = '{32'hA5A5_FFFF, 32'h5A5A_0000, 32, 16'hA5A5, 16'h5A5A};
    tv[2] = '{32'h8000_0000, 32'h7FFF_0000, 16, 16'h8000, 16'h7FFF};
    tv[3] = '{32'hFFFF_1234, 32'h0000_4321, 24, 16'hFFFF, 16'h0000};
    tv[4] = '{32'h5555_0000, 32'hAAAA_FFFF, 17, 16'h5555, 16'hAAAA};
    #3;
    do_reset();
    chk("reset_outputs", {left_sample, right_sample}, 32'h0);
    chk("reset_flags", {sample_valid, locked, frame_err, overrun}, 4'h0);

    foreach (tv[i]) begin
      do_reset();
      send_slot(1, 32'h0, 16);
      x0 = xfers; v0 = vcyc; e0 = errs;
      send_slot(0, tv[i].l, tv[i].slot);
      send_slot(1, tv[i].r, tv[i].slot);
      chk($sformatf("tv%0d_xfers", i), xfers - x0, 1);
      chk($sformatf("tv%0d_valid_cycles", i), vcyc - v0, 1);
      chk($sformatf("tv%0d_left", i), last_l, tv[i].el);
      chk($sformatf("tv%0d_right", i), last_r, tv[i].er);
      chk($sformatf("tv%0d_locked_noerr", i), {locked, 31'(errs - e0)}, {1'b1, 31'd0});
    end

    // Consumer stalled across three frames.
    do_reset();
    @(posedge clk); #2 sample_ready = 0;
    send_slot(1, 32'h0, 16);
    x0 = xfers;
    for (int f = 0; f < 3; f++) begin
      send_slot(0, {16'(2 * f + 1), 16'h0}, 16);
      send_slot(1, {16'(2 * f + 2), 16'h0}, 16);
    end
    chk("ovr_left", left_sample, 16'h0001);
    chk("ovr_right", right_sample, 16'h0002);
    chk("ovr_valid", sample_valid, 1);
    chk("ovr_set", overrun, 1);
    @(posedge clk); #2 err_clr = 1;
    @(posedge clk); #2 err_clr = 0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_valid_held", sample_valid, 1);
    @(posedge clk); #2 sample_ready = 1;
    @(posedge clk); #2;
    chk("ovr_one_xfer", xfers - x0, 1);
    chk("ovr_valid_drop", sample_valid, 0);

    // Short left word, then recovery.
    do_reset();
    send_slot(1, 32'h0, 16);
    e0 = errs; x0 = xfers; v0 = vcyc;
    send_slot(0, 32'hFFFF_FFFF, 10);
    chk("short_err", errs - e0, 1);
    chk("short_unlocked", locked, 0);
    send_slot(1, 32'h1111_0000, 16);
    chk("short_relocked", locked, 1);
    send_slot(0, 32'h7FFF_0000, 16);
    send_slot(1, 32'h8000_0000, 16);
    chk("short_err_once", errs - e0, 1);
    chk("short_xfers", xfers - x0, 1);
    chk("short_pair", {last_l, last_r}, 32'h7FFF_8000);

    // LRCK stuck low after lock.
    do_reset();
    send_slot(1, 32'h0, 16);
    e0 = errs;
    for (int k = 0; k < 40; k++) begin
      rise(k == 39, 1'b0);
      if (k == 31) chk("stuck_32_ok", {locked, 31'(errs - e0)}, {1'b1, 31'd0});
      if (k == 32) chk("stuck_33_err", {locked, 31'(errs - e0)}, {1'b0, 31'd1});
    end
    chk("stuck_err_once", errs - e0, 1);

    // Asynchronous reset mid right word.
    do_reset();
    send_slot(1, 32'h0, 16);
    send_slot(0, 32'h1111_0000, 16);
    send_slot(1, 32'h2222_0000, 16);
    send_slot(0, 32'h3333_0000, 16);
    for (int k = 0; k < 8; k++) rise(1'b1, 1'b1);
    rst_n = 0;
    #1;
    chk("rst_mid_data", {left_sample, right_sample}, 32'h0);
    chk("rst_mid_flags", {sample_valid, locked, frame_err, overrun}, 4'h0);
    #19 rst_n = 1;
    x0 = xfers;
    for (int k = 0; k < 8; k++) rise(k == 7 ? 1'b0 : 1'b1, 1'b0);
    send_slot(0, 32'h4444_0000, 16);
    chk("rst_no_early_valid", xfers - x0, 0);
    send_slot(1, 32'h5555_0000, 16);
    chk("rst_relock_xfer", xfers - x0, 1);
    chk("rst_relock_pair", {last_l, last_r}, 32'h4444_5555);

    // Randomized stream against the framing model.
    do_reset();
    rl_q.delete(); rd_q.delete(); got_q.delete(); exp_q.delete();
    e0 = errs;
    rec = 1;
    c = 1;
    for (int s = 0; s < 60; s++) begin
      send_slot(c, $urandom, pool[$urandom_range(0, 12)]);
      c = ~c;
    end
    rec = 0;
    run_model(merr, mlk);
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("rnd_pair%0d", i), got_q[i], exp_q[i]);
    chk("rnd_errs", errs - e0, merr);
    chk("rnd_locked", locked, mlk);
    chk("rnd_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
